// File: rtl/lfsr10.sv
// ---------------------------------------------------------------------------
// lfsr10 -- 10-bit maximal-length Fibonacci LFSR, polynomial x^10 + x^7 + 1.
//
// Free-running pseudo-random pattern source. It walks all 1023 non-zero
// states, so the period is 1023. It provides a run enable, a seed load, and a
// one-cycle wrap pulse each time the state comes back to SEED.
//
// Parameters
//   SEED    reset/restart state; must be non-zero (default 10'h3FF)
//
// Ports
//   clk     in   1   system clock; all state changes on the rising edge
//   rst     in   1   synchronous reset, active high
//   en      in   1   advance enable (tie high for free-running use)
//   ld      in   1   load seed_i into the register (takes priority over en)
//   seed_i  in   10  value to load when ld=1; zero is replaced by SEED
//   data_o  out  10  current LFSR state, driven straight from the register
//   wrap_o  out  1   registered pulse, high for one cycle when state == SEED
//
// Control interface: there is no valid/ready handshake. Each control input is
// sampled at every rising edge. The priority order is rst, then ld, then en.
// The effect of an edge shows up on data_o/wrap_o in the following cycle.
// ---------------------------------------------------------------------------
module lfsr10 #(
  parameter logic [9:0] SEED = 10'h3FF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ld,
  input  logic [9:0] seed_i,
  output logic [9:0] data_o,
  output logic       wrap_o
);

  logic [9:0] r_q;
  logic       r_wrap;

  logic       w_fb;
  logic [9:0] w_q_next;
  logic [9:0] w_load_val;

  // Shift-left step. Taps at bit 9 and bit 6 realise x^10 + x^7 + 1.
  // All-zero is the one state the XOR feedback can never leave. If it is ever
  // reached (for example through an upset), the next step restarts at SEED.
  always_comb begin
    w_fb     = r_q[9] ^ r_q[6];
    w_q_next = {r_q[8:0], w_fb};
    if (r_q == 10'd0) begin
      w_q_next = SEED;
    end
  end

  // A zero seed would lock the register up, so it is replaced by SEED.
  always_comb begin
    w_load_val = seed_i;
    if (seed_i == 10'd0) begin
      w_load_val = SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= SEED;
      r_wrap <= 1'b0;
    end else if (ld) begin
      r_q    <= w_load_val;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_q    <= w_q_next;
      r_wrap <= (w_q_next == SEED);
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign data_o = r_q;
  assign wrap_o = r_wrap;

endmodule

// File: tb/tb_lfsr10.sv
// ---------------------------------------------------------------------------
// tb_lfsr10 -- directed self-checking bench for lfsr10.
// Inputs change 1 time unit after the rising edge. Outputs are sampled at the
// same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_lfsr10;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ld;
  logic [9:0] seed_i;
  logic [9:0] data_o;
  logic       wrap_o;

  int checks;
  int failures;

  lfsr10 dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .ld     (ld),
    .seed_i (seed_i),
    .data_o (data_o),
    .wrap_o (wrap_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [9:0] exp_seq [8];
    exp_seq = '{10'h3FE, 10'h3FC, 10'h3F8, 10'h3F0,
                10'h3E0, 10'h3C0, 10'h380, 10'h301};
    rst = 1'b1; en = 1'b1; ld = 1'b0; seed_i = 10'h000;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (data_o !== 10'h3FF || wrap_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d] data_o=%h wrap_o=%b required data_o=3ff wrap_o=0",
                 i, data_o, wrap_o);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (data_o !== exp_seq[i]) begin
        failures++;
        $display("FAIL reset_seq[%0d] data_o=%h required %h", i, data_o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_period();
    bit seen [1024];
    int cycles;
    int distinct;
    int bad_vals;
    int wraps;
    int wrap_cycle;
    int one_cycle;
    bit done;
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    distinct = 0; bad_vals = 0; wraps = 0;
    wrap_cycle = -1; one_cycle = -1; cycles = 0; done = 1'b0;

    rst = 1'b1; en = 1'b1; ld = 1'b0;
    step();
    rst = 1'b0;
    while (!done && cycles < 1200) begin
      step();
      cycles++;
      if (wrap_o === 1'b1) begin
        wraps++;
        wrap_cycle = cycles;
      end
      if (data_o === 10'h3FF) begin
        done = 1'b1;
      end else if (data_o === 10'h000 || seen[data_o]) begin
        bad_vals++;
      end else begin
        seen[data_o] = 1'b1;
        distinct++;
        if (data_o === 10'h001) one_cycle = cycles;
      end
    end

    checks++;
    if (!done) begin
      failures++;
      $display("FAIL period_return data_o never returned to 3ff within %0d cycles", cycles);
    end
    checks++;
    if (cycles != 1023) begin
      failures++;
      $display("FAIL period_length cycles=%0d required 1023", cycles);
    end
    checks++;
    if (bad_vals != 0) begin
      failures++;
      $display("FAIL period_unique zero_or_repeat=%0d required 0", bad_vals);
    end
    // The return to 3FF is not counted here, so 1022 other non-zero values remain.
    checks++;
    if (distinct != 1022) begin
      failures++;
      $display("FAIL period_distinct distinct=%0d required 1022", distinct);
    end
    checks++;
    if (one_cycle < 1 || one_cycle >= cycles) begin
      failures++;
      $display("FAIL period_reach_one cycle=%0d required within (0,%0d)", one_cycle, cycles);
    end
    checks++;
    if (wraps != 1 || wrap_cycle != 1023) begin
      failures++;
      $display("FAIL period_wrap pulses=%0d at_cycle=%0d required 1 at 1023", wraps, wrap_cycle);
    end
    // The pulse must be a single cycle.
    step();
    checks++;
    if (wrap_o !== 1'b0 || data_o !== 10'h3FE) begin
      failures++;
      $display("FAIL period_after_wrap data_o=%h wrap_o=%b required data_o=3fe wrap_o=0",
               data_o, wrap_o);
    end
  endtask

  task automatic test_load_one();
    logic [9:0] exp_seq [7];
    exp_seq = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h081};
    // en is also high here, so the loaded value must not be stepped (ld wins).
    en = 1'b1; ld = 1'b1; seed_i = 10'h001;
    step();
    ld = 1'b0;
    checks++;
    if (data_o !== 10'h001 || wrap_o !== 1'b0) begin
      failures++;
      $display("FAIL load_one data_o=%h wrap_o=%b required data_o=001 wrap_o=0", data_o, wrap_o);
    end
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (data_o !== exp_seq[i]) begin
        failures++;
        $display("FAIL load_one_seq[%0d] data_o=%h required %h", i, data_o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_load_zero();
    en = 1'b1; ld = 1'b1; seed_i = 10'h000;
    step();
    ld = 1'b0;
    checks++;
    if (data_o !== 10'h3FF || wrap_o !== 1'b0) begin
      failures++;
      $display("FAIL load_zero data_o=%h wrap_o=%b required data_o=3ff wrap_o=0", data_o, wrap_o);
    end
    step();
    checks++;
    if (data_o !== 10'h3FE) begin
      failures++;
      $display("FAIL load_zero_next data_o=%h required 3fe", data_o);
    end
  endtask

  task automatic test_enable_hold();
    rst = 1'b1; en = 1'b1; ld = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (data_o !== 10'h3F0) begin
      failures++;
      $display("FAIL hold_setup data_o=%h required 3f0", data_o);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (data_o !== 10'h3F0 || wrap_o !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d] data_o=%h wrap_o=%b required data_o=3f0 wrap_o=0",
                 i, data_o, wrap_o);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (data_o !== 10'h3E0) begin
      failures++;
      $display("FAIL hold_resume data_o=%h required 3e0", data_o);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; en = 1'b1; ld = 1'b1; seed_i = 10'h155;
    step();
    checks++;
    if (data_o !== 10'h3FF || wrap_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_priority data_o=%h wrap_o=%b required data_o=3ff wrap_o=0",
               data_o, wrap_o);
    end
    rst = 1'b0;
    step();
    checks++;
    if (data_o !== 10'h155) begin
      failures++;
      $display("FAIL ld_after_rst data_o=%h required 155", data_o);
    end
    // 155 has bit 6 set and bit 9 clear, so the feedback bit is 1 and the next value is 2AB.
    ld = 1'b0;
    step();
    checks++;
    if (data_o !== 10'h2AB) begin
      failures++;
      $display("FAIL step_from_155 data_o=%h required 2ab", data_o);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; ld = 1'b0; seed_i = 10'h000;
    test_reset();
    test_period();
    test_load_one();
    test_load_zero();
    test_enable_hold();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
